// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
//   Shared constants and helpers for the stream demultiplexer:
//   - DEF_DW / DEF_N : default data width and channel count
//   - DROP_CW        : width of the saturating drop counter
//   - sel_width()    : select width for N channels (clog2, never below 1)
package stream_demux_pkg;

    localparam int DEF_DW  = 8;
    localparam int DEF_N   = 16;
    localparam int DROP_CW = 8;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// stream_demux_slot
//   One-entry holding register for a single output channel.
//   Ports:
//     clk, rst_n  - clock, synchronous active-low reset
//     load        - capture din this edge (only raised when free=1)
//     din         - word to capture
//     out_valid   - slot holds a word (FULL)
//     out_ready   - consumer accepts the held word
//     out_data    - held word; keeps its last value while EMPTY
//     free        - slot can take a word this cycle (EMPTY, or draining)
//
//   state   | meaning
//   --------+-----------------------------------------
//   S_EMPTY | nothing held, out_valid = 0
//   S_FULL  | word held, out_valid = 1
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] din,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          free
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]    r_state;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
        end else if (load) begin
            // Covers the drain-and-load case: slot stays FULL with new data.
            r_state <= S_FULL;
            r_data  <= din;
        end else if (r_state == S_FULL && out_ready) begin
            r_state <= S_EMPTY;
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign out_data  = r_data;
    assign free      = (r_state == S_EMPTY) || out_ready;

endmodule

// File: rtl/stream_demux.sv
// stream_demux
//   Registered 1-to-N stream demultiplexer with valid/ready handshakes.
//   A word goes to channel in_sel, or to every channel when in_bcast=1.
//   Selects >= N are accepted, discarded, flagged on err_sel (next cycle)
//   and counted in drop_cnt (saturating).
//   Ports:
//     clk, rst_n            - clock, synchronous active-low reset
//     in_valid/in_ready     - producer handshake
//     in_data, in_sel       - word and destination channel
//     in_bcast              - deliver to all channels
//     out_valid/out_ready   - per-channel consumer handshake (N bits)
//     out_data              - channel i at [i*DW +: DW]
//     err_sel               - registered pulse after a dropped word
//     drop_cnt              - saturating count of dropped words
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int DW = DEF_DW,
    parameter  int N  = DEF_N,
    localparam int SW = sel_width(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [SW-1:0]     in_sel,
    input  logic              in_bcast,
    output logic [N-1:0]      out_valid,
    input  logic [N-1:0]      out_ready,
    output logic [N*DW-1:0]   out_data,
    output logic              err_sel,
    output logic [DROP_CW-1:0] drop_cnt
);

    logic [N-1:0]       w_free;
    logic [2**SW-1:0]   w_free_pad;
    logic [N-1:0]       w_load;
    logic               w_sel_ok;
    logic               w_accept;
    logic               w_drop;

    logic               r_err_sel;
    logic [DROP_CW-1:0] r_drop_cnt;

    // Pad the free vector to the full select range so the index below is
    // always in bounds; the padded entries are masked by w_sel_ok anyway.
    assign w_free_pad = (2**SW)'(w_free);
    assign w_sel_ok   = (int'(in_sel) < N);

    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &w_free;
        end else if (w_sel_ok) begin
            in_ready = w_free_pad[in_sel];
        end
    end

    assign w_accept = in_valid && in_ready;
    assign w_drop   = w_accept && !in_bcast && !w_sel_ok;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_slot
            assign w_load[g] = w_accept && (in_bcast || (w_sel_ok && (int'(in_sel) == g)));

            stream_demux_slot #(.DW(DW)) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (w_load[g]),
                .din       (in_data),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_data  (out_data[g*DW +: DW]),
                .free      (w_free[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_sel  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_err_sel <= w_drop;
            if (w_drop && !(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign err_sel  = r_err_sel;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux
//   Instance A (N=16): directed sweep, stall, broadcast and reset cases.
//   Instance B (N=12): invalid selects, randomized traffic against a
//   per-channel behavioural model, and drop counter saturation.
module tb_stream_demux;

    localparam int DW = 8;
    localparam int NA = 16;
    localparam int NB = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic             a_rst_n;
    logic             a_in_valid;
    logic             a_in_ready;
    logic [DW-1:0]    a_in_data;
    logic [3:0]       a_in_sel;
    logic             a_in_bcast;
    logic [NA-1:0]    a_out_valid;
    logic [NA-1:0]    a_out_ready;
    logic [NA*DW-1:0] a_out_data;
    logic             a_err_sel;
    logic [7:0]       a_drop_cnt;

    stream_demux #(.DW(DW), .N(NA)) dut_a (
        .clk       (clk),
        .rst_n     (a_rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .in_bcast  (a_in_bcast),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .err_sel   (a_err_sel),
        .drop_cnt  (a_drop_cnt)
    );

    // ---------------- instance B ----------------
    logic             b_rst_n;
    logic             b_in_valid;
    logic             b_in_ready;
    logic [DW-1:0]    b_in_data;
    logic [3:0]       b_in_sel;
    logic             b_in_bcast;
    logic [NB-1:0]    b_out_valid;
    logic [NB-1:0]    b_out_ready;
    logic [NB*DW-1:0] b_out_data;
    logic             b_err_sel;
    logic [7:0]       b_drop_cnt;

    stream_demux #(.DW(DW), .N(NB)) dut_b (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .in_bcast  (b_in_bcast),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .err_sel   (b_err_sel),
        .drop_cnt  (b_drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_drive(input logic v, input logic [3:0] sel, input logic [7:0] d, input logic bc);
        a_in_valid = v;
        a_in_sel   = sel;
        a_in_data  = d;
        a_in_bcast = bc;
    endtask

    // Behavioural model of instance B
    logic       m_valid [NB];
    logic [7:0] m_data  [NB];
    logic       m_err;
    int         m_cnt;

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 8'h00;
        end
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    function automatic logic model_ready();
        logic all_free;
        all_free = 1'b1;
        for (int i = 0; i < NB; i++)
            if (m_valid[i] && !b_out_ready[i]) all_free = 1'b0;
        if (b_in_bcast) return all_free;
        if (int'(b_in_sel) >= NB) return 1'b1;
        return !m_valid[b_in_sel] || b_out_ready[b_in_sel];
    endfunction

    task automatic model_step(input logic rdy);
        logic acc;
        logic drop;
        acc  = b_in_valid && rdy;
        drop = acc && !b_in_bcast && (int'(b_in_sel) >= NB);
        for (int i = 0; i < NB; i++) begin
            if (acc && (b_in_bcast || int'(b_in_sel) == i)) begin
                m_valid[i] = 1'b1;
                m_data[i]  = b_in_data;
            end else if (m_valid[i] && b_out_ready[i]) begin
                m_valid[i] = 1'b0;
            end
        end
        m_err = drop;
        if (drop && m_cnt < 255) m_cnt++;
    endtask

    task automatic model_compare(input string tag);
        logic [NB-1:0]    ev;
        logic [NB*DW-1:0] ed;
        for (int i = 0; i < NB; i++) begin
            ev[i]          = m_valid[i];
            ed[i*DW +: DW] = m_data[i];
        end
        check({tag, "_valid"}, 128'(b_out_valid), 128'(ev));
        check({tag, "_data"},  128'(b_out_data),  128'(ed));
        check({tag, "_err"},   128'(b_err_sel),   128'(m_err));
        check({tag, "_cnt"},   128'(b_drop_cnt),  128'(m_cnt));
    endtask

    initial begin
        logic       rdy;
        logic       stalled;
        logic [127:0] exp_all;

        a_rst_n = 1'b0; a_out_ready = '1; a_drive(1'b0, 4'd0, 8'h00, 1'b0);
        b_rst_n = 1'b0; b_out_ready = '1;
        b_in_valid = 1'b0; b_in_sel = 4'd0; b_in_data = 8'h00; b_in_bcast = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("a_rst_valid", 128'(a_out_valid), 128'(0));
        check("a_rst_data",  128'(a_out_data),  128'(0));
        check("a_rst_cnt",   128'(a_drop_cnt),  128'(0));
        check("b_rst_err",   128'(b_err_sel),   128'(0));
        @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // ---- unicast sweep ----
        for (int i = 0; i < NA; i++) begin
            @(negedge clk);
            a_drive(1'b1, 4'(i), 8'(8'hA0 + i), 1'b0);
            #1 check("sweep_ready", 128'(a_in_ready), 128'(1));
            @(posedge clk); #1;
            check("sweep_valid", 128'(a_out_valid), 128'(16'(1) << i));
            check("sweep_data",  128'(a_out_data[i*DW +: DW]), 128'(8'hA0 + i));
        end
        @(negedge clk); a_drive(1'b0, 4'd0, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("sweep_drained", 128'(a_out_valid), 128'(0));

        // ---- stall / backpressure ----
        @(negedge clk); a_out_ready = 16'hFFF7; a_drive(1'b1, 4'd3, 8'h11, 1'b0);
        @(posedge clk); #1;
        check("stall_v1", 128'(a_out_valid), 128'(16'h0008));
        @(negedge clk); a_drive(1'b1, 4'd3, 8'h22, 1'b0);
        #1 check("stall_ready0", 128'(a_in_ready), 128'(0));
        @(posedge clk); #1;
        check("stall_hold", 128'(a_out_data[3*DW +: DW]), 128'(8'h11));
        @(negedge clk); a_out_ready = 16'hFFFF;
        #1 check("stall_ready1", 128'(a_in_ready), 128'(1));
        @(posedge clk); #1;
        check("stall_v2",   128'(a_out_valid), 128'(16'h0008));
        check("stall_data", 128'(a_out_data[3*DW +: DW]), 128'(8'h22));
        @(negedge clk); a_drive(1'b0, 4'd0, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("stall_empty", 128'(a_out_valid), 128'(0));

        // ---- broadcast ----
        @(negedge clk); a_out_ready = 16'hFF7F; a_drive(1'b1, 4'd7, 8'h77, 1'b0);
        @(posedge clk);
        @(negedge clk); a_drive(1'b1, 4'd9, 8'h5A, 1'b1);
        #1 check("bc_ready0", 128'(a_in_ready), 128'(0));
        @(posedge clk); #1;
        check("bc_wait_valid", 128'(a_out_valid), 128'(16'h0080));
        check("bc_wait_data",  128'(a_out_data[7*DW +: DW]), 128'(8'h77));
        @(negedge clk); a_out_ready = 16'hFFFF;
        #1 check("bc_ready1", 128'(a_in_ready), 128'(1));
        @(posedge clk); #1;
        exp_all = 128'({16{8'h5A}});
        check("bc_valid", 128'(a_out_valid), 128'(16'hFFFF));
        check("bc_data",  a_out_data, exp_all);
        @(negedge clk); a_drive(1'b0, 4'd0, 8'h00, 1'b0);

        // ---- reset mid-operation ----
        @(negedge clk); a_out_ready = 16'h0000; a_drive(1'b1, 4'd0, 8'h01, 1'b0);
        @(negedge clk); a_drive(1'b1, 4'd5, 8'h05, 1'b0);
        @(negedge clk); a_drive(1'b1, 4'd9, 8'h09, 1'b0);
        @(posedge clk); #1;
        check("mid_loaded", 128'(a_out_valid), 128'(16'h0221));
        @(negedge clk); a_rst_n = 1'b0; a_drive(1'b0, 4'd0, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("mid_rst_valid", 128'(a_out_valid), 128'(0));
        check("mid_rst_data",  128'(a_out_data),  128'(0));
        check("mid_rst_cnt",   128'(a_drop_cnt),  128'(0));
        @(negedge clk); a_rst_n = 1'b1; a_out_ready = 16'hFFFF; a_drive(1'b1, 4'd2, 8'h3C, 1'b0);
        #1 check("post_rst_ready", 128'(a_in_ready), 128'(1));
        @(posedge clk); #1;
        check("post_rst_valid", 128'(a_out_valid), 128'(16'h0004));
        check("post_rst_data",  128'(a_out_data[2*DW +: DW]), 128'(8'h3C));
        check("a_no_err", 128'({a_err_sel, a_drop_cnt}), 128'(0));
        @(negedge clk); a_drive(1'b0, 4'd0, 8'h00, 1'b0);

        // ---- instance B: three invalid selects ----
        @(negedge clk);
        b_in_valid = 1'b1; b_in_sel = 4'd13; b_in_bcast = 1'b0; b_in_data = 8'hEE;
        #1 check("drop_ready", 128'(b_in_ready), 128'(1));
        check("drop_err_pre", 128'(b_err_sel), 128'(0));
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check("drop_err",   128'(b_err_sel),   128'(1));
            check("drop_cnt",   128'(b_drop_cnt),  128'(k));
            check("drop_valid", 128'(b_out_valid), 128'(0));
        end
        @(negedge clk); b_in_valid = 1'b0;
        @(posedge clk); #1;
        check("drop_err_off", 128'(b_err_sel), 128'(0));
        m_cnt = 3;

        // ---- instance B: randomized traffic against the model ----
        stalled = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!stalled) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_in_sel   = 4'($urandom_range(0, 15));
                b_in_bcast = ($urandom_range(0, 7) == 0);
                b_in_data  = 8'($urandom);
            end
            for (int i = 0; i < NB; i++) b_out_ready[i] = ($urandom_range(0, 3) != 0);
            rdy = model_ready();
            #1 check("rand_ready", 128'(b_in_ready), 128'(rdy));
            model_step(rdy);
            stalled = b_in_valid && !rdy;
            @(posedge clk); #1;
            model_compare("rand");
        end

        // ---- instance B: drop counter saturation ----
        @(negedge clk);
        b_out_ready = '1;
        b_in_valid = 1'b1; b_in_sel = 4'd14; b_in_bcast = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("sat_cnt", 128'(b_drop_cnt), 128'(255));
        check("sat_err", 128'(b_err_sel),  128'(1));
        @(negedge clk); b_in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
